// File: rtl/sha256_digest_hexout.sv
// -----------------------------------------------------------------------------
// sha256_digest_hexout
//   Consumes the 8 x 32-bit word stream of a SHA-256 core (MSW first).
//   It assembles the 256-bit digest, compares it against a reference digest,
//   and streams the digest as 64 ASCII hex characters (optionally followed by
//   CR/LF) over a byte valid/ready interface.
//
// Parameters
//   EMIT_NEWLINE    1: append CR (8'h0D) and LF (8'h0A) after the hex chars
//   UPPERCASE       1: hex letters 'A'-'F'; 0: 'a'-'f'
//
// Ports
//   clk             clock, all logic on posedge
//   rst_n           synchronous active-low reset
//   hash_word       digest word (MSW first)
//   hash_word_valid word qualifier; there is no backpressure toward the source
//   expected_digest reference digest, sampled when the 8th word is captured
//   out_byte        ASCII character toward the TX stage
//   out_valid       out_byte is valid
//   out_ready       TX stage accepts out_byte when out_valid && out_ready
//   digest          last assembled digest, held until the next capture
//   digest_valid    one-cycle pulse when digest/match update
//   match           digest == expected_digest, held until the next update
//   busy            a frame is being emitted; new words are dropped
//   overrun         sticky flag: a word was dropped while busy
// -----------------------------------------------------------------------------
module sha256_digest_hexout #(
  parameter bit EMIT_NEWLINE = 1'b1,
  parameter bit UPPERCASE    = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  hash_word,
  input  logic         hash_word_valid,
  input  logic [255:0] expected_digest,
  output logic [7:0]   out_byte,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         match,
  output logic         busy,
  output logic         overrun
);

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_SEND    = 2'd1;
  localparam logic [1:0] ST_TRAIL   = 2'd2;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  // Letter base chosen so that base + nibble(10..15) lands on 'A'/'a'.
  localparam logic [7:0] LETTER_BASE = UPPERCASE ? 8'h37 : 8'h57;
  localparam logic [7:0] DIGIT_BASE  = 8'h30;

  logic [1:0]   state_q, state_d;
  logic [2:0]   word_cnt_q, word_cnt_d;
  logic [255:0] digest_sh_q, digest_sh_d;
  logic [255:0] digest_q, digest_d;
  logic         match_q, match_d;
  logic         dvalid_q, dvalid_d;
  logic [5:0]   char_idx_q, char_idx_d;
  logic         lf_q, lf_d;          // TRAIL phase: 0 = CR pending, 1 = LF pending
  logic         overrun_q, overrun_d;

  logic [255:0] assembled;
  logic [7:0]   nib_base;
  logic [3:0]   nibble;
  logic [7:0]   hex_char;
  logic         active;

  // Shift register contents with the incoming word dropped into its slot.
  // Used both for the partial store and, on the 8th word, as the full digest
  // so the capture happens without an extra cycle.
  always_comb begin
    assembled = digest_sh_q;
    for (int i = 0; i < 8; i++) begin
      if (word_cnt_q == 3'(i)) assembled[255-32*i -: 32] = hash_word;
    end
  end

  // Character char_idx is nibble (63 - char_idx) counted from the LSB end.
  assign nib_base = 8'd252 - {char_idx_q, 2'b00};
  assign nibble   = digest_q[nib_base +: 4];
  assign hex_char = (nibble < 4'd10) ? (DIGIT_BASE + {4'h0, nibble})
                                     : (LETTER_BASE + {4'h0, nibble});

  assign active = (state_q == ST_SEND) || (state_q == ST_TRAIL);

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    digest_sh_d = digest_sh_q;
    digest_d    = digest_q;
    match_d     = match_q;
    dvalid_d    = 1'b0;
    char_idx_d  = char_idx_q;
    lf_d        = lf_q;
    overrun_d   = overrun_q;

    case (state_q)
      ST_COLLECT: begin
        if (hash_word_valid) begin
          digest_sh_d = assembled;
          if (word_cnt_q == 3'd7) begin
            word_cnt_d = 3'd0;
            digest_d   = assembled;
            match_d    = (assembled == expected_digest);
            dvalid_d   = 1'b1;
            char_idx_d = 6'd0;
            state_d    = ST_SEND;
          end else begin
            word_cnt_d = word_cnt_q + 3'd1;
          end
        end
      end

      ST_SEND: begin
        if (out_ready) begin
          if (char_idx_q == 6'd63) begin
            char_idx_d = 6'd0;
            lf_d       = 1'b0;
            word_cnt_d = 3'd0;
            state_d    = EMIT_NEWLINE ? ST_TRAIL : ST_COLLECT;
          end else begin
            char_idx_d = char_idx_q + 6'd1;
          end
        end
      end

      ST_TRAIL: begin
        if (out_ready) begin
          if (lf_q) begin
            lf_d       = 1'b0;
            word_cnt_d = 3'd0;
            state_d    = ST_COLLECT;
          end else begin
            lf_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_COLLECT;
      end
    endcase

    // No backpressure exists toward the hash core, so a word landing while a
    // frame is in flight (including the edge of the final transfer) is lost.
    if (active && hash_word_valid) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      word_cnt_q  <= 3'd0;
      digest_sh_q <= '0;
      digest_q    <= '0;
      match_q     <= 1'b0;
      dvalid_q    <= 1'b0;
      char_idx_q  <= 6'd0;
      lf_q        <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      digest_sh_q <= digest_sh_d;
      digest_q    <= digest_d;
      match_q     <= match_d;
      dvalid_q    <= dvalid_d;
      char_idx_q  <= char_idx_d;
      lf_q        <= lf_d;
      overrun_q   <= overrun_d;
    end
  end

  // Output byte is decoded from registered state; it cannot change while
  // the character is stalled because char_idx/lf only advance on a transfer.
  always_comb begin
    out_byte = 8'h00;
    case (state_q)
      ST_SEND:  out_byte = hex_char;
      ST_TRAIL: out_byte = lf_q ? CHAR_LF : CHAR_CR;
      default:  out_byte = 8'h00;
    endcase
  end

  assign out_valid    = active;
  assign busy         = active;
  assign digest       = digest_q;
  assign digest_valid = dvalid_q;
  assign match        = match_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sha256_digest_hexout.sv
module tb_sha256_digest_hexout;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  hash_word;
  logic         hash_word_valid;
  logic [255:0] expected_digest;
  logic         out_ready;

  logic [7:0]   out_byte,  u_out_byte;
  logic         out_valid, u_out_valid;
  logic [255:0] digest,    u_digest;
  logic         digest_valid, u_digest_valid;
  logic         match,     u_match;
  logic         busy,      u_busy;
  logic         overrun,   u_overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  localparam logic [255:0] D_T1 =
    256'hc21919e5_b04c8a06_164b68bd_57293a97_c7ef18d7_371feea6_8f3872cd_cb23b743;

  always #5 clk = ~clk;

  sha256_digest_hexout #(.EMIT_NEWLINE(1'b1), .UPPERCASE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .hash_word(hash_word), .hash_word_valid(hash_word_valid),
    .expected_digest(expected_digest), .out_byte(out_byte), .out_valid(out_valid),
    .out_ready(out_ready), .digest(digest), .digest_valid(digest_valid), .match(match),
    .busy(busy), .overrun(overrun));

  sha256_digest_hexout #(.EMIT_NEWLINE(1'b0), .UPPERCASE(1'b1)) dut_u (
    .clk(clk), .rst_n(rst_n), .hash_word(hash_word), .hash_word_valid(hash_word_valid),
    .expected_digest(expected_digest), .out_byte(u_out_byte), .out_valid(u_out_valid),
    .out_ready(out_ready), .digest(u_digest), .digest_valid(u_digest_valid), .match(u_match),
    .busy(u_busy), .overrun(u_overrun));

  // Reference: the frame is the digest written as hex text, most significant
  // nibble first, optionally followed by CR LF.
  function automatic void build_exp(input logic [255:0] d, input bit upper, input bit nl);
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      logic [255:0] t;
      int n;
      logic [7:0] c;
      t = d >> (252 - 4*i);
      n = int'(t[3:0]);
      if (n < 10) c = 8'(48 + n);
      else        c = 8'((upper ? 65 : 97) + n - 10);
      exp_q.push_back(c);
    end
    if (nl) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  function automatic logic [255:0] rand_digest();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d = {d[223:0], 32'($urandom)};
    return d;
  endfunction

  // Feeds the 8 words MSW first; leaves the bench at posedge+1 after the 8th word edge.
  task automatic send_words(input logic [255:0] d, input int gap_max);
    logic [255:0] t;
    t = d;
    for (int i = 0; i < 8; i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      hash_word_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      hash_word = t[255:224];
      t = t << 32;
      hash_word_valid = 1'b1;
      @(posedge clk); #1;
    end
    hash_word_valid = 1'b0;
  endtask

  // Drains nbytes from the selected DUT against exp_q, optionally with random
  // out_ready and an injected stray word at iteration pulse_at.
  task automatic collect(input int nbytes, input bit rnd, input bit use_u,
                         input int pulse_at, input bit check_end, output int cycles);
    int got;
    bit stalled;
    logic [7:0] prev, b, e;
    logic v, rdy;
    got = 0; stalled = 0; cycles = 0; prev = 8'h00;
    while (got < nbytes && cycles < 3000) begin
      v = use_u ? u_out_valid : out_valid;
      b = use_u ? u_out_byte  : out_byte;
      if (stalled) begin
        checks++;
        if (v !== 1'b1 || b !== prev) begin
          errors++;
          $display("FAIL stall_hold: valid=%b byte=%h required valid=1 byte=%h", v, b, prev);
        end
      end
      if (!use_u && cycles > 0 && digest_valid !== 1'b0) begin
        errors++;
        $display("FAIL dvalid_in_send: digest_valid=%b required 0", digest_valid);
      end
      if (v !== 1'b1) begin
        errors++;
        $display("FAIL stream_valid: out_valid=%b required 1 at byte %0d", v, got);
        break;
      end
      if (cycles == pulse_at) begin
        hash_word = $urandom;
        hash_word_valid = 1'b1;
      end else begin
        hash_word_valid = 1'b0;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (rdy) begin
        e = exp_q.pop_front();
        checks++;
        if (b !== e) begin
          errors++;
          $display("FAIL stream_byte[%0d]: got %h required %h", got, b, e);
        end
        got++;
        stalled = 0;
      end else begin
        stalled = 1;
        prev = b;
      end
      @(posedge clk); #1;
      cycles++;
    end
    hash_word_valid = 1'b0;
    if (got < nbytes) begin
      errors++;
      $display("FAIL stream_timeout: got %0d bytes required %0d", got, nbytes);
    end
    if (check_end) begin
      checks++;
      if ((use_u ? u_busy : busy) !== 1'b0 || (use_u ? u_out_valid : out_valid) !== 1'b0) begin
        errors++;
        $display("FAIL frame_end: busy/out_valid still high, required 0 after %0d bytes", nbytes);
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((busy || u_busy) && n < 300) begin @(posedge clk); #1; n++; end
    if (busy || u_busy) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b u_busy=%b required 0", busy, u_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hash_word = '0; hash_word_valid = 1'b0;
    expected_digest = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_stream: valid=%b busy=%b byte=%h required 0 0 00", out_valid, busy, out_byte);
    end
    checks++;
    if (digest !== '0 || digest_valid !== 1'b0 || match !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: digest=%h dv=%b match=%b ovr=%b required all 0",
               digest, digest_valid, match, overrun);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_match();
    int cyc;
    wait_idle();
    expected_digest = D_T1;
    build_exp(D_T1, 0, 1);
    send_words(D_T1, 0);
    checks++;
    if (digest_valid !== 1'b1 || out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t1_latency: dv=%b ov=%b busy=%b required 1 1 1", digest_valid, out_valid, busy);
    end
    checks++;
    if (digest !== D_T1 || match !== 1'b1) begin
      errors++;
      $display("FAIL t1_digest: digest=%h match=%b required %h 1", digest, match, D_T1);
    end
    collect(66, 0, 0, -1, 1, cyc);
    checks++;
    if (cyc !== 66) begin
      errors++;
      $display("FAIL t1_frame_cycles: got %0d required 66", cyc);
    end
    checks++;
    if (match !== 1'b1 || digest !== D_T1) begin
      errors++;
      $display("FAIL t1_hold: match=%b required 1", match);
    end
  endtask

  task automatic test_mismatch();
    int cyc;
    wait_idle();
    expected_digest = D_T1 ^ 256'h1;
    build_exp(D_T1, 0, 1);
    send_words(D_T1, 0);
    checks++;
    if (digest_valid !== 1'b1 || match !== 1'b0) begin
      errors++;
      $display("FAIL t2_match: dv=%b match=%b required 1 0", digest_valid, match);
    end
    collect(66, 0, 0, -1, 1, cyc);
  endtask

  task automatic test_gapped_stall();
    int cyc;
    for (int k = 0; k < 2; k++) begin
      logic [255:0] d;
      wait_idle();
      d = rand_digest();
      expected_digest = (k == 0) ? d : rand_digest();
      build_exp(d, 0, 1);
      send_words(d, 5);
      checks++;
      if (digest !== d || match !== (k == 0)) begin
        errors++;
        $display("FAIL t3_digest[%0d]: digest=%h match=%b required %h %b", k, digest, match, d, k == 0);
      end
      collect(66, 1, 0, -1, 1, cyc);
    end
  endtask

  task automatic test_upper_nonl();
    int cyc;
    logic [255:0] d;
    wait_idle();
    d = rand_digest();
    d[255:232] = 24'hABCDEF;
    d[23:0]    = 24'hFEDCBA;
    expected_digest = d;
    build_exp(d, 1, 0);
    send_words(d, 2);
    checks++;
    if (u_digest_valid !== 1'b1 || u_digest !== d || u_match !== 1'b1) begin
      errors++;
      $display("FAIL t4_digest: dv=%b digest=%h match=%b required 1 %h 1", u_digest_valid, u_digest, u_match, d);
    end
    collect(64, 1, 1, -1, 1, cyc);
  endtask

  task automatic test_overrun();
    int cyc;
    logic [255:0] d1, d2;
    wait_idle();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL t5_pre_overrun: got %b required 0", overrun);
    end
    d1 = rand_digest();
    expected_digest = d1;
    build_exp(d1, 0, 1);
    send_words(d1, 0);
    collect(66, 1, 0, 10, 1, cyc);
    checks++;
    if (overrun !== 1'b1 || digest !== d1 || match !== 1'b1) begin
      errors++;
      $display("FAIL t5_overrun: ovr=%b digest=%h match=%b required 1 %h 1", overrun, digest, match, d1);
    end
    wait_idle();
    d2 = rand_digest();
    expected_digest = d2;
    build_exp(d2, 0, 1);
    send_words(d2, 1);
    checks++;
    if (digest !== d2 || match !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL t5_next: digest=%h match=%b ovr=%b required %h 1 1", digest, match, overrun, d2);
    end
    collect(66, 0, 0, -1, 1, cyc);
  endtask

  task automatic test_reset_midstream();
    int cyc;
    logic [255:0] d;
    wait_idle();
    d = rand_digest();
    expected_digest = d;
    build_exp(d, 0, 1);
    send_words(d, 0);
    collect(20, 0, 0, -1, 0, cyc);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_byte !== 8'h00 || digest !== '0 ||
        digest_valid !== 1'b0 || match !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL t6_reset: ov=%b busy=%b byte=%h dv=%b match=%b ovr=%b required all 0",
               out_valid, busy, out_byte, digest_valid, match, overrun);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL t6_quiet: out_valid=%b required 0", out_valid);
    end
    d = rand_digest();
    expected_digest = d;
    build_exp(d, 0, 1);
    send_words(d, 0);
    checks++;
    if (digest !== d || match !== 1'b1) begin
      errors++;
      $display("FAIL t6_fresh: digest=%h match=%b required %h 1", digest, match, d);
    end
    collect(66, 1, 0, -1, 1, cyc);
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_gapped_stall();
    test_upper_nonl();
    test_overrun();
    test_reset_midstream();
    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
